// File: rtl/imem_responder.sv
// Instruction-memory responder: same-cycle grant, fixed-latency in-order read responses
// from a word-wide RAM, outstanding-request tracking, and a byte-enabled side-band load port.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        instr_rvalid_o,
    input  logic        stall_i,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i,
    input  logic [3:0]  load_be_i
);

    localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
    localparam int unsigned CntW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] SizeBytes = 32'(DEPTH_WORDS * 4);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [LATENCY-1:0] valid_q, err_q;
    logic [31:0]     rdata_q [LATENCY];

    logic [31:0]     req_off, load_off;
    logic [IdxW-1:0] req_idx, load_idx;
    logic            req_err, load_hit;
    logic [31:0]     rd_word;

    // Address decode for the fetch request and the load port.
    always_comb begin
        req_off  = instr_addr_i - BASE_ADDR;
        req_err  = (req_off >= SizeBytes) | instr_addr_i[0];
        req_idx  = req_off[IdxW+1:2];
        // Erroring requests never touch the RAM and return zero data.
        rd_word  = req_err ? 32'h0 : mem_q[req_idx];
        load_off = load_addr_i - BASE_ADDR;
        load_hit = (load_off < SizeBytes);
        load_idx = load_off[IdxW+1:2];
    end

    // Grant looks only at the registered count; a same-cycle response does not free a slot.
    assign instr_gnt_o = instr_req_i & rstn & ~stall_i & (outstanding_q < MaxCnt);

    // Outstanding count: +1 per grant, -1 per response, unchanged when both happen.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({instr_gnt_o, instr_rvalid_o})
            2'b10:   outstanding_d = outstanding_q + CntW'(1);
            2'b01:   outstanding_d = outstanding_q - CntW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Response pipeline and counter; reset discards every in-flight response.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q       <= '0;
            err_q         <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                rdata_q[i] <= 32'h0;
            end
        end else begin
            valid_q[0]    <= instr_gnt_o;
            err_q[0]      <= instr_gnt_o & req_err;
            rdata_q[0]    <= instr_gnt_o ? rd_word : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
            outstanding_q <= outstanding_d;
        end
    end

    // RAM write port; not gated by reset so boot logic can load while the core is held.
    // A same-edge read captured above sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (load_we_i && load_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (load_be_i[b]) begin
                    mem_q[load_idx][8*b +: 8] <= load_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Last pipeline stage drives the bus; stage data is zero whenever its valid bit is clear.
    assign instr_rvalid_o = valid_q[LATENCY-1];
    assign instr_err_o    = err_q[LATENCY-1];
    assign instr_rdata_o  = rdata_q[LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: five instances with different LATENCY/MAX_OUTSTANDING
// share one stimulus bus; each section checks the instance it targets.
module tb_imem_responder;

    logic        clk;
    logic        rstn, req, stall, load_we;
    logic [31:0] addr, load_addr, load_wdata;
    logic [3:0]  load_be;

    // Index: 0 = L1/M2, 1 = L2/M2, 2 = L2/M3, 3 = L2/M1, 4 = L3/M2
    logic [4:0]  gnt_w, rvalid_w, err_w;
    logic [31:0] rdata_w [5];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] words [4] = '{32'h0000_0513, 32'h0015_0513, 32'hAAAA_AAAA, 32'h0000_0033};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    imem_responder #(.LATENCY(1), .MAX_OUTSTANDING(2)) u_l1 (
        .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt_w[0]),
        .instr_addr_i(addr), .instr_rdata_o(rdata_w[0]), .instr_err_o(err_w[0]),
        .instr_rvalid_o(rvalid_w[0]), .stall_i(stall), .load_we_i(load_we),
        .load_addr_i(load_addr), .load_wdata_i(load_wdata), .load_be_i(load_be)
    );
    imem_responder #(.LATENCY(2), .MAX_OUTSTANDING(2)) u_l2m2 (
        .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt_w[1]),
        .instr_addr_i(addr), .instr_rdata_o(rdata_w[1]), .instr_err_o(err_w[1]),
        .instr_rvalid_o(rvalid_w[1]), .stall_i(stall), .load_we_i(load_we),
        .load_addr_i(load_addr), .load_wdata_i(load_wdata), .load_be_i(load_be)
    );
    imem_responder #(.LATENCY(2), .MAX_OUTSTANDING(3)) u_l2m3 (
        .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt_w[2]),
        .instr_addr_i(addr), .instr_rdata_o(rdata_w[2]), .instr_err_o(err_w[2]),
        .instr_rvalid_o(rvalid_w[2]), .stall_i(stall), .load_we_i(load_we),
        .load_addr_i(load_addr), .load_wdata_i(load_wdata), .load_be_i(load_be)
    );
    imem_responder #(.LATENCY(2), .MAX_OUTSTANDING(1)) u_l2m1 (
        .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt_w[3]),
        .instr_addr_i(addr), .instr_rdata_o(rdata_w[3]), .instr_err_o(err_w[3]),
        .instr_rvalid_o(rvalid_w[3]), .stall_i(stall), .load_we_i(load_we),
        .load_addr_i(load_addr), .load_wdata_i(load_wdata), .load_be_i(load_be)
    );
    imem_responder #(.LATENCY(3), .MAX_OUTSTANDING(2)) u_l3 (
        .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt_w[4]),
        .instr_addr_i(addr), .instr_rdata_o(rdata_w[4]), .instr_err_o(err_w[4]),
        .instr_rvalid_o(rvalid_w[4]), .stall_i(stall), .load_we_i(load_we),
        .load_addr_i(load_addr), .load_wdata_i(load_wdata), .load_be_i(load_be)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        load_we    = 1'b1;
        load_addr  = a;
        load_wdata = d;
        load_be    = be;
        tick();
        load_we    = 1'b0;
    endtask

    // Single read on the LATENCY=1 instance: grant now, response in the next cycle.
    task automatic single_read(input logic [31:0] a, input logic e_err, input logic [31:0] e_data);
        req  = 1'b1;
        addr = a;
        #1;
        chk($sformatf("rd %h gnt", a), 32'(gnt_w[0]), 32'd1);
        tick();
        req = 1'b0;
        chk($sformatf("rd %h rvalid", a), 32'(rvalid_w[0]), 32'd1);
        chk($sformatf("rd %h err", a), 32'(err_w[0]), 32'(e_err));
        chk($sformatf("rd %h rdata", a), rdata_w[0], e_data);
    endtask

    // Requester that advances its address only on grant; checks 8 cycles of gnt/rvalid
    // (bit c of eg/erv is cycle c) and in-order data on instance sel.
    task automatic run_seq(input int sel, input int ngr, input logic [7:0] eg,
                           input logic [7:0] erv);
        int ng = 0;
        int nr = 0;
        for (int c = 0; c < 8; c++) begin
            req  = (ng < ngr);
            addr = 32'(ng) * 32'd4;
            #1;
            chk($sformatf("seq%0d gnt c%0d", sel, c), 32'(gnt_w[sel]), 32'(eg[c]));
            chk($sformatf("seq%0d rvalid c%0d", sel, c), 32'(rvalid_w[sel]), 32'(erv[c]));
            if (rvalid_w[sel] === 1'b1 && nr < 4) begin
                chk($sformatf("seq%0d rdata c%0d", sel, c), rdata_w[sel], words[nr]);
                nr++;
            end
            if (sel == 1) begin
                chk($sformatf("l2m2 outstanding<=2 c%0d", c),
                    32'(u_l2m2.outstanding_q <= 2'd2), 32'd1);
            end
            if (gnt_w[sel] === 1'b1) ng++;
            tick();
        end
        req = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        rstn       = 1'b0;
        req        = 1'b1;
        stall      = 1'b0;
        addr       = 32'h0;
        load_we    = 1'b0;
        load_addr  = 32'h0;
        load_wdata = 32'h0;
        load_be    = 4'h0;

        // Program image loaded while reset is held; an out-of-range load must not alias word 0.
        load_word(32'h0000_0000, words[0], 4'hF);
        chk("gnt while in reset", 32'(gnt_w), 32'h0);
        load_word(32'h0000_1000, 32'h1234_5678, 4'hF);
        load_word(32'h0000_0004, words[1], 4'hF);
        load_word(32'h0000_0008, words[2], 4'hF);
        chk("gnt while in reset 2", 32'(gnt_w), 32'h0);
        load_word(32'h0000_000C, words[3], 4'hF);
        load_word(32'h0000_0FFC, 32'hDEAD_BEEF, 4'hF);

        chk("reset rvalid", 32'(rvalid_w), 32'h0);
        chk("reset err", 32'(err_w), 32'h0);
        for (int i = 0; i < 5; i++) chk($sformatf("reset rdata%0d", i), rdata_w[i], 32'h0);
        chk("reset outstanding l1", 32'(u_l1.outstanding_q), 32'h0);
        chk("reset outstanding l3", 32'(u_l3.outstanding_q), 32'h0);

        // Basic read, LATENCY=1.
        rstn = 1'b1;
        addr = 32'h0;
        #1;
        chk("basic gnt0", 32'(gnt_w[0]), 32'd1);
        tick();
        addr = 32'h4;
        #1;
        chk("basic gnt1", 32'(gnt_w[0]), 32'd1);
        chk("basic rvalid0", 32'(rvalid_w[0]), 32'd1);
        chk("basic rdata0", rdata_w[0], 32'h0000_0513);
        chk("basic err0", 32'(err_w[0]), 32'd0);
        tick();
        req = 1'b0;
        chk("basic rvalid1", 32'(rvalid_w[0]), 32'd1);
        chk("basic rdata1", rdata_w[0], 32'h0015_0513);
        tick();
        chk("basic idle rvalid", 32'(rvalid_w[0]), 32'd0);
        chk("basic idle rdata", rdata_w[0], 32'h0);
        repeat (6) tick();

        // Back-to-back: L2/M3 sustains a grant every cycle; L2/M2 stalls once per pair.
        run_seq(2, 4, 8'b0000_1111, 8'b0011_1100);
        run_seq(1, 4, 8'b0001_1011, 8'b0110_1100);
        // Throttled: L2/M1 grants every third cycle; rvalid lands on non-grant cycles.
        run_seq(3, 3, 8'b0100_1001, 8'b0010_0100);

        // Error decode on the LATENCY=1 instance.
        single_read(32'h0000_1000, 1'b1, 32'h0);
        single_read(32'h0000_0001, 1'b1, 32'h0);
        single_read(32'h0000_0006, 1'b0, 32'h0015_0513);
        single_read(32'h0000_0FFC, 1'b0, 32'hDEAD_BEEF);
        single_read(32'hFFFF_FFFC, 1'b1, 32'h0);
        single_read(32'h0000_0000, 1'b0, 32'h0000_0513);
        repeat (6) tick();

        // stall_i blocks every grant and produces no response.
        stall = 1'b1;
        req   = 1'b1;
        addr  = 32'h0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("stall gnt c%0d", c), 32'(gnt_w), 32'h0);
            chk($sformatf("stall rvalid c%0d", c), 32'(rvalid_w), 32'h0);
            tick();
        end
        stall = 1'b0;
        req   = 1'b0;
        tick();

        // Mid-flight reset on the LATENCY=3 instance: the granted response is discarded.
        req  = 1'b1;
        addr = 32'h4;
        #1;
        chk("midrst gnt", 32'(gnt_w[4]), 32'd1);
        tick();
        req  = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midrst outstanding", 32'(u_l3.outstanding_q), 32'h0);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("midrst rvalid c%0d", c), 32'(rvalid_w), 32'h0);
            tick();
        end

        // Load/read collision on word 2: read sees old data, next read sees merged bytes.
        req        = 1'b1;
        addr       = 32'h8;
        load_we    = 1'b1;
        load_addr  = 32'h8;
        load_wdata = 32'h5555_5555;
        load_be    = 4'b0011;
        #1;
        chk("collide gnt", 32'(gnt_w[0]), 32'd1);
        tick();
        load_we = 1'b0;
        req     = 1'b0;
        chk("collide rvalid", 32'(rvalid_w[0]), 32'd1);
        chk("collide old data", rdata_w[0], 32'hAAAA_AAAA);
        single_read(32'h0000_0008, 1'b0, 32'hAAAA_5555);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
